// File: rtl/lut6_table_arbiter.sv
// Runtime-reloadable 64x1 LUT6-style table shared by NUM_REQ requesters through a
// round-robin arbiter, with a drain/serial-load/commit sequence for mask updates.
module lut6_table_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [63:0] INIT_MASK = 64'h80000000_00000000
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [6*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_dout,
  input  logic                 cfg_start,
  input  logic                 cfg_bit,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic [63:0]          mask_out
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD, ST_COMMIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [2:0]  r_ptr;
  logic [63:0] r_mask;
  logic [63:0] r_shadow;

  logic        r_s1_vld;
  logic [5:0]  r_s1_idx;
  logic [2:0]  r_s1_id;
  logic        r_s2_vld;
  logic [2:0]  r_s2_id;
  logic        r_s2_dout;

  logic [7:0]  w_valid_pad;
  logic [5:0]  w_din_pad [8];
  logic        w_gnt_any;
  logic [2:0]  w_gnt_id;
  logic [3:0]  w_cand;

  // Pad requester inputs to 8 lanes so a 3-bit id can index them for any NUM_REQ.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_used
        assign w_valid_pad[gi] = req_valid[gi];
        assign w_din_pad[gi]   = req_din[6*gi +: 6];
      end else begin : g_unused
        assign w_valid_pad[gi] = 1'b0;
        assign w_din_pad[gi]   = 6'd0;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign req_ready[gi] = w_gnt_any && (w_gnt_id == 3'(gi));
      assign rsp_valid[gi] = r_s2_vld && (r_s2_id == 3'(gi));
    end
  endgenerate

  // cfg_start suppresses grants in its acceptance cycle so the drain sees no new work.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 3'd0;
    w_cand    = 4'd0;
    if (r_state == ST_RUN && !cfg_start) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        w_cand = {1'b0, r_ptr} + 4'(off);
        if (w_cand >= 4'(NUM_REQ)) begin
          w_cand = w_cand - 4'(NUM_REQ);
        end
        if (!w_gnt_any && w_valid_pad[w_cand[2:0]]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = w_cand[2:0];
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    cfg_busy     = (r_state != ST_RUN);
    cfg_done     = (r_state == ST_COMMIT);
    case (r_state)
      ST_RUN:    if (cfg_start)       w_state_next = ST_DRAIN;
      ST_DRAIN:  if (r_cnt == 6'd1)   w_state_next = ST_LOAD;
      ST_LOAD:   if (r_cnt == 6'd63)  w_state_next = ST_COMMIT;
      ST_COMMIT:                      w_state_next = ST_RUN;
      default:                        w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_cnt restarts on every state change: DRAIN counts 0..1, LOAD counts 0..63.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt    <= 6'd0;
      r_shadow <= 64'd0;
      r_mask   <= INIT_MASK;
    end else begin
      if (r_state != w_state_next) begin
        r_cnt <= 6'd0;
      end else if (r_state == ST_DRAIN || r_state == ST_LOAD) begin
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == ST_LOAD) begin
        r_shadow[r_cnt] <= cfg_bit;
      end
      if (r_state == ST_COMMIT) begin
        r_mask <= r_shadow;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr <= 3'd0;
    end else if (w_gnt_any) begin
      r_ptr <= (w_gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : w_gnt_id + 3'd1;
    end
  end

  // The table read happens in stage 2; grants never occur during reload, so the
  // mask seen here always equals the mask active at grant time.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_s1_vld  <= 1'b0;
      r_s1_idx  <= 6'd0;
      r_s1_id   <= 3'd0;
      r_s2_vld  <= 1'b0;
      r_s2_id   <= 3'd0;
      r_s2_dout <= 1'b0;
    end else begin
      r_s1_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_s1_idx <= w_din_pad[w_gnt_id];
        r_s1_id  <= w_gnt_id;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_id   <= r_s1_id;
      r_s2_dout <= r_s1_vld ? r_mask[r_s1_idx] : 1'b0;
    end
  end

  assign rsp_dout = r_s2_dout;
  assign mask_out = r_mask;

endmodule

// File: tb/tb_lut6_table_arbiter.sv
// Scoreboard bench for lut6_table_arbiter: grants push expected responses that are
// popped and compared two cycles later; reload timelines are checked cycle by cycle.
module tb_lut6_table_arbiter;
  localparam int          N    = 4;
  localparam logic [63:0] INIT = 64'h80000000_00000000;

  logic           clk = 1'b0;
  logic           arst;
  logic [N-1:0]   req_valid;
  logic [6*N-1:0] req_din;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic           rsp_dout;
  logic           cfg_start;
  logic           cfg_bit;
  logic           cfg_busy;
  logic           cfg_done;
  logic [63:0]    mask_out;

  lut6_table_arbiter #(.NUM_REQ(N), .INIT_MASK(INIT)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_din(req_din), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .cfg_start(cfg_start), .cfg_bit(cfg_bit),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .mask_out(mask_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    int   id;
    logic dout;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] m_mask;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard and grant capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (arst) begin
      sb.delete();
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("rsp_missing_due", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(4'(1) << e.id));
        check("rsp_dout", 64'(rsp_dout), 64'(e.dout));
        $display("rsp cyc=%0d id=%0d dout=%0b", cyc, e.id, rsp_dout);
      end else begin
        check("rsp_idle", 64'(rsp_valid), 64'd0);
      end
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      check("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{due: cyc + 2, id: i, dout: m_mask[req_din[6*i +: 6]]});
        end
      end
    end
  end

  task automatic do_reset();
    tick();
    arst      = 1'b1;
    req_valid = '0;
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    m_mask    = INIT;
    @(negedge clk);
    check("rst_outputs", 64'({req_ready, rsp_valid, rsp_dout, cfg_busy, cfg_done}), 64'd0);
    check("rst_mask", mask_out, INIT);
    tick();
    arst = 1'b0;
  endtask

  // Caller is just past the posedge of acceptance cycle T.
  task automatic reload(input logic [63:0] nm, input int pulse_k);
    cfg_start = 1'b1;
    @(negedge clk);
    check("cfg_accept", 64'({cfg_busy, cfg_done, req_ready}), 64'd0);
    for (int c = 1; c <= 67; c++) begin
      tick();
      cfg_start = (pulse_k >= 0 && c == 3 + pulse_k);
      cfg_bit   = (c >= 3 && c <= 66) ? nm[c-3] : 1'b0;
      @(negedge clk);
      check("cfg_window", 64'({cfg_busy, cfg_done, req_ready}), 64'({1'b1, (c == 67), 4'b0000}));
      check("mask_hold", mask_out, m_mask);
    end
    tick();
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    m_mask    = nm;
    @(negedge clk);
    check("cfg_end", 64'({cfg_busy, cfg_done}), 64'd0);
    check("mask_new", mask_out, nm);
  endtask

  initial begin
    arst      = 1'b1;
    req_valid = '0;
    req_din   = '0;
    cfg_start = 1'b0;
    cfg_bit   = 1'b0;
    m_mask    = INIT;
    repeat (2) @(posedge clk);
    do_reset();

    // Single lookups on requester 0 at both ends of the index range.
    req_valid = 4'b0001;
    req_din   = 24'd63;
    @(negedge clk);
    check("ready_single63", 64'(req_ready), 64'b0001);
    tick();
    req_din = 24'd0;
    @(negedge clk);
    check("ready_single0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Round-robin with every requester valid.
    do_reset();
    req_valid = 4'hF;
    req_din   = {6'd63, 6'd0, 6'd62, 6'd63};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(4'(1) << (i % 4)));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Old-mask response in DRAIN, then reload to mask 1 with requests pending.
    req_valid = 4'b0001;
    req_din   = {6'd0, 6'd63, 6'd0, 6'd63};
    @(negedge clk);
    check("ready_pre_cfg", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'hF;
    reload(64'h0000_0000_0000_0001, -1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("rr_after_cfg", 64'(req_ready), 64'(4'(1) << ((i + 1) % 4)));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Reset during LOAD at k=30 discards the partial load.
    cfg_start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      cfg_start = 1'b0;
      cfg_bit   = (c >= 3);
      if (c == 33) begin
        arst   = 1'b1;
        m_mask = INIT;
      end
    end
    @(negedge clk);
    check("arst_midload", 64'({cfg_busy, cfg_done}), 64'd0);
    check("arst_mask", mask_out, INIT);
    tick();
    arst    = 1'b0;
    cfg_bit = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      check("no_done_after_arst", 64'({cfg_busy, cfg_done}), 64'd0);
      tick();
    end
    req_valid = 4'b0001;
    req_din   = 24'd63;
    @(negedge clk);
    check("ready_after_arst", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Extra cfg_start during LOAD must not disturb the reload timeline.
    reload({$urandom, $urandom}, 10);
    for (int i = 0; i < 30; i++) begin
      tick();
      req_valid = 4'($urandom_range(0, 15));
      req_din   = 24'($urandom);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
